pulse_window_gen: RTL and testbench
===================================

Name: pulse_window_gen

Overview:
- Multi-channel, parametrised successor to the fixed mod-500 window generator.
- A shared free-running period counter drives CHANNELS independent active-low window outputs.
- Period and per-channel windows are run-time programmable and shadow-buffered, so updates take effect only at a period boundary. Updates never cause glitches.
- Supports a continuous mode and a triggered one-shot mode. Used as the timing and strobe source for downstream control logic.

Parameters:
- WIDTH, 9, bit width of the counter, period and window bounds.
- CHANNELS, 4, number of independent window outputs.
- RST_PERIOD, 500, period loaded at reset (must be ≥2 and <2^WIDTH).
- RST_LO, 20, window start loaded into every channel at reset.
- RST_HI, 90, window end (exclusive) loaded into every channel at reset.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = counter advances; 0 = freeze count, state and f.
- mode  in  1  0 = continuous, 1 = one-shot; sampled only in IDLE.
- start  in  1  one-shot trigger; ignored unless in IDLE with mode=1.
- cfg_period_we  in  1  write cfg_period into the pending period.
- cfg_period  in  WIDTH  new period; writes with a value <2 are ignored.
- cfg_we  in  1  write the pending window of channel cfg_ch.
- cfg_ch  in  $clog2(CHANNELS)  channel select; out-of-range values are ignored.
- cfg_lo  in  WIDTH  window start (inclusive).
- cfg_hi  in  WIDTH  window end (exclusive).
- count  out  WIDTH  current counter value.
- f  out  CHANNELS  per-channel output; 0 inside the window, 1 outside.
- wrap  out  1  one-cycle pulse when count==period-1 (the last count of a period).
- busy  out  1  1 while in RUN.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE, count=0, f=all 1, wrap=0, busy=0.
  - Active and pending period = RST_PERIOD.
  - Active and pending lo/hi of every channel = RST_LO/RST_HI.
- States: IDLE, RUN.
  - In IDLE: count held at 0, f all 1, wrap 0.
  - IDLE → RUN when enable=1 and either mode=0, or mode=1 and start=1. The RUN cycle that follows shows count=0.
- Counting in RUN with enable=1:
  - count ← (count==period-1) ? 0 : count+1.
  - wrap=1 in the cycle where count==period-1, otherwise 0.
  - Continuous mode: wrap returns count to 0 and stays in RUN.
  - One-shot: after the wrap cycle, go to IDLE (count=0, busy=0). Exactly one period is produced per start.
  - mode is latched on IDLE→RUN; changes to mode during RUN have no effect until the next IDLE.
- enable=0: count, state, f and all active registers hold; wrap=0.
  - Config writes still update the pending registers.
  - A start while enable=0 is ignored.
- Window output:
  - f is registered and aligned with count: f[i]=0 iff state=RUN and lo_i ≤ count < hi_i, using the active bounds.
  - lo_i ≥ hi_i: f[i] stays 1 for the whole period.
  - hi_i > period: the window runs to period-1 and ends at wrap.
- Shadowing:
  - cfg writes go to pending registers immediately (writes in the same cycle to different targets all take effect).
  - Pending values are copied to active on the wrap cycle, so the new values apply from count=0.
  - In IDLE the copy happens every cycle.
  - Of two writes to the same channel, the later one wins.
- count arithmetic is unsigned, modulo period; count never reaches or exceeds period.
- Reset mid-run aborts immediately: next cycle count=0, f=all 1, pending writes are discarded.

Test Plan:
- Defaults, mode=0, enable=1 after reset:
  - f[i]=0 for exactly count 20..89 (70 cycles) of every 500-cycle period.
  - wrap pulses at count=499.
  - busy=1 from the first RUN cycle.
- Reprogramming: write ch1 lo=100, hi=110 and period=200 at count=50.
  - Current period still uses 500 and 20..90.
  - Next period: wrap at 199; f[1] low for counts 100..109; the other channels keep 20..89.
- One-shot: mode=1, start pulse in IDLE.
  - One 500-cycle period; wrap at 499, then IDLE, busy=0, f all 1.
  - A second start issued during RUN is ignored.
- Enable freeze: deassert enable for 10 cycles at count=30.
  - count stays 30, f stays 0, wrap stays 0.
  - Counting resumes at 31.
- Edge configurations:
  - ch2 lo=hi=40 → f[2] always 1.
  - ch3 lo=480, hi=511 → low for 480..499.
  - period write of 1 → ignored.
- Reset asserted at count=60 → next cycle count=0, f=all 1, state IDLE, then a normal restart.

Source files
------------

// File: rtl/pulse_window_gen.sv
// pulse_window_gen
// Multi-channel window generator. A shared period counter runs from 0 to
// period-1, and each channel drives an active-low window output that is low
// while lo <= count < hi. The period and the per-channel windows are written
// into pending registers and copied to the active set only at a period
// boundary, or on any enabled IDLE cycle, so a reprogram never cuts a period
// short and never produces a glitch.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   enable          1 = advance; 0 = freeze count, state and f (wrap forced 0)
//   mode, start     0 = continuous, 1 = one-shot; start triggers a one-shot
//                   run from IDLE
//   cfg_period_we   load cfg_period into the pending period (values < 2 dropped)
//   cfg_we          load cfg_lo/cfg_hi into the pending window of cfg_ch
//   count           current counter value
//   f               per-channel window, 0 inside [lo, hi), 1 outside
//   wrap            high during the last count of a period
//   busy            high while running
module pulse_window_gen #(
    parameter int WIDTH      = 9,
    parameter int CHANNELS   = 4,
    parameter int RST_PERIOD = 500,
    parameter int RST_LO     = 20,
    parameter int RST_HI     = 90,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                mode,
    input  logic                start,
    input  logic                cfg_period_we,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_lo,
    input  logic [WIDTH-1:0]    cfg_hi,
    output logic [WIDTH-1:0]    count,
    output logic [CHANNELS-1:0] f,
    output logic                wrap,
    output logic                busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                mode_q, mode_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [CHANNELS-1:0] f_q, f_d;
    logic [WIDTH-1:0]    act_period_q, act_period_d;
    logic [WIDTH-1:0]    pend_period_q, pend_period_d;
    logic [WIDTH-1:0]    act_lo_q [CHANNELS];
    logic [WIDTH-1:0]    act_lo_d [CHANNELS];
    logic [WIDTH-1:0]    act_hi_q [CHANNELS];
    logic [WIDTH-1:0]    act_hi_d [CHANNELS];
    logic [WIDTH-1:0]    pend_lo_q [CHANNELS];
    logic [WIDTH-1:0]    pend_lo_d [CHANNELS];
    logic [WIDTH-1:0]    pend_hi_q [CHANNELS];
    logic [WIDTH-1:0]    pend_hi_d [CHANNELS];
    logic                last_count;
    logic                wrap_c;
    logic                copy_c;

    // Next-state logic. Pending writes are resolved first so that a write
    // landing in the wrap cycle is already part of the next period. The
    // window output is computed from the next count, state and active bounds
    // so that f lines up with count in the same cycle.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        count_d       = count_q;
        pend_period_d = pend_period_q;
        pend_lo_d     = pend_lo_q;
        pend_hi_d     = pend_hi_q;
        act_period_d  = act_period_q;
        act_lo_d      = act_lo_q;
        act_hi_d      = act_hi_q;
        f_d           = '1;

        if (cfg_period_we && (cfg_period >= WIDTH'(2))) begin
            pend_period_d = cfg_period;
        end
        if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
            pend_lo_d[cfg_ch] = cfg_lo;
            pend_hi_d[cfg_ch] = cfg_hi;
        end

        last_count = (count_q == (act_period_q - WIDTH'(1)));
        wrap_c     = (state_q == ST_RUN) && enable && last_count;
        // IDLE refreshes the active set while enabled; a disabled block
        // keeps its active registers untouched.
        copy_c     = enable && ((state_q == ST_IDLE) || wrap_c);

        if (copy_c) begin
            act_period_d = pend_period_d;
            act_lo_d     = pend_lo_d;
            act_hi_d     = pend_hi_d;
        end

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (enable && (!mode || start)) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end
            default: begin
                if (enable) begin
                    if (last_count) begin
                        count_d = '0;
                        if (mode_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
        endcase

        // An empty window (lo >= hi) never matches; a window with hi beyond
        // the period simply ends when the counter wraps.
        for (int i = 0; i < CHANNELS; i++) begin
            f_d[i] = !((state_d == ST_RUN) &&
                       (count_d >= act_lo_d[i]) && (count_d < act_hi_d[i]));
        end
    end

    // State registers. Reset returns everything, pending included, to the
    // power-up configuration.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            count_q       <= '0;
            f_q           <= '1;
            act_period_q  <= WIDTH'(RST_PERIOD);
            pend_period_q <= WIDTH'(RST_PERIOD);
            for (int i = 0; i < CHANNELS; i++) begin
                act_lo_q[i]  <= WIDTH'(RST_LO);
                act_hi_q[i]  <= WIDTH'(RST_HI);
                pend_lo_q[i] <= WIDTH'(RST_LO);
                pend_hi_q[i] <= WIDTH'(RST_HI);
            end
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            count_q       <= count_d;
            f_q           <= f_d;
            act_period_q  <= act_period_d;
            pend_period_q <= pend_period_d;
            act_lo_q      <= act_lo_d;
            act_hi_q      <= act_hi_d;
            pend_lo_q     <= pend_lo_d;
            pend_hi_q     <= pend_hi_d;
        end
    end

    assign count = count_q;
    assign f     = f_q;
    assign wrap  = wrap_c;
    assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_pulse_window_gen.sv
// tb_pulse_window_gen
// Directed bench for pulse_window_gen with default parameters: a short
// vector table for start-up, then hand-written sequences for reprogramming,
// edge windows, enable freeze, mid-run reset and one-shot operation.
module tb_pulse_window_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       mode;
    logic       start;
    logic       cfg_period_we;
    logic [8:0] cfg_period;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [8:0] cfg_lo;
    logic [8:0] cfg_hi;
    logic [8:0] count;
    logic [3:0] f;
    logic       wrap;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_lo [4];
    int exp_hi [4];

    typedef struct {
        logic       en;
        logic       md;
        logic       st;
        logic [8:0] cnt;
        logic [3:0] fo;
        logic       wr;
        logic       bz;
    } vec_t;

    vec_t vecs [7];

    pulse_window_gen dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .mode          (mode),
        .start         (start),
        .cfg_period_we (cfg_period_we),
        .cfg_period    (cfg_period),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_lo        (cfg_lo),
        .cfg_hi        (cfg_hi),
        .count         (count),
        .f             (f),
        .wrap          (wrap),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // One clock edge; outputs are sampled 1 ns later, inputs stay as set.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] e_cnt,
                               input logic [3:0] e_f, input logic e_wr,
                               input logic e_bz);
        tests_run++;
        if ({count, f, wrap, busy} !== {e_cnt, e_f, e_wr, e_bz}) begin
            tests_failed++;
            $display("[TB] FAIL %s: got count=%0d f=%b wrap=%b busy=%b, want count=%0d f=%b wrap=%b busy=%b",
                     name, count, f, wrap, busy, e_cnt, e_f, e_wr, e_bz);
        end
    endtask

    function automatic logic [3:0] windowF(input int c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !((c >= exp_lo[i]) && (c < exp_hi[i]));
        end
        return r;
    endfunction

    task automatic setDefaults();
        for (int i = 0; i < 4; i++) begin
            exp_lo[i] = 20;
            exp_hi[i] = 90;
        end
    endtask

    // Steps through counts first..last of a running period, expecting the
    // window pattern held in exp_lo/exp_hi and wrap at period-1.
    task automatic runSpan(input string name, input int first, input int last,
                           input int period);
        for (int c = first; c <= last; c++) begin
            applyStimulus();
            checkOutput($sformatf("%s@%0d", name, c), 9'(c), windowF(c),
                        (c == period - 1), 1'b1);
        end
    endtask

    task automatic writeWindow(input int ch, input int lo, input int hi);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_lo = 9'(lo);
        cfg_hi = 9'(hi);
    endtask

    task automatic writePeriod(input int p);
        cfg_period_we = 1'b1;
        cfg_period    = 9'(p);
    endtask

    task automatic clearWrites();
        cfg_we        = 1'b0;
        cfg_period_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        mode = 1'b0;
        start = 1'b0;
        cfg_period_we = 1'b0;
        cfg_period = '0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_lo = '0;
        cfg_hi = '0;
        setDefaults();

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("reset", 9'd0, 4'hF, 1'b0, 1'b0);
        reset = 1'b0;

        // Start-up table: idle hold, continuous start, freeze, ignored
        // mode/start changes while running.
        vecs[0] = '{en: 1'b0, md: 1'b0, st: 1'b0, cnt: 9'd0, fo: 4'hF, wr: 1'b0, bz: 1'b0};
        vecs[1] = '{en: 1'b1, md: 1'b0, st: 1'b0, cnt: 9'd0, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        vecs[2] = '{en: 1'b1, md: 1'b0, st: 1'b0, cnt: 9'd1, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        vecs[3] = '{en: 1'b0, md: 1'b0, st: 1'b0, cnt: 9'd1, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        vecs[4] = '{en: 1'b0, md: 1'b1, st: 1'b0, cnt: 9'd1, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        vecs[5] = '{en: 1'b1, md: 1'b1, st: 1'b1, cnt: 9'd2, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        vecs[6] = '{en: 1'b1, md: 1'b0, st: 1'b0, cnt: 9'd3, fo: 4'hF, wr: 1'b0, bz: 1'b1};
        for (int v = 0; v < 7; v++) begin
            enable = vecs[v].en;
            mode   = vecs[v].md;
            start  = vecs[v].st;
            applyStimulus();
            checkOutput($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].fo,
                        vecs[v].wr, vecs[v].bz);
        end
        enable = 1'b1;
        mode   = 1'b0;
        start  = 1'b0;

        // Default window over the rest of the first period; ch1 and period
        // are rewritten together at count 50 but must wait for the wrap.
        runSpan("dflt", 4, 49, 500);
        writeWindow(1, 100, 110);
        writePeriod(200);
        runSpan("reprog", 50, 50, 500);
        clearWrites();
        runSpan("oldcfg", 51, 499, 500);

        // New period: 200 long, ch1 low for 100..109. Edge configs are
        // written early in this period for use in the next one.
        exp_lo[1] = 100;
        exp_hi[1] = 110;
        runSpan("newcfg", 0, 9, 200);
        writeWindow(2, 40, 40);
        runSpan("wr_ch2", 10, 10, 200);
        writeWindow(3, 480, 511);
        runSpan("wr_ch3", 11, 11, 200);
        clearWrites();
        writePeriod(500);
        runSpan("wr_p500", 12, 12, 200);
        writePeriod(1);
        runSpan("wr_p1", 13, 13, 200);
        clearWrites();
        writeWindow(0, 5, 6);
        runSpan("wr_ch0a", 14, 14, 200);
        writeWindow(0, 30, 60);
        runSpan("wr_ch0b", 15, 15, 200);
        clearWrites();
        runSpan("newcfg", 16, 199, 200);

        // Period 500 again (write of 1 dropped), ch0 30..59, ch2 empty,
        // ch3 running past the period end.
        exp_lo[0] = 30;  exp_hi[0] = 60;
        exp_lo[2] = 40;  exp_hi[2] = 40;
        exp_lo[3] = 480; exp_hi[3] = 511;
        runSpan("edge", 0, 30, 500);

        // Enable freeze at count 30; a start during the freeze has no effect.
        enable = 1'b0;
        start  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            checkOutput($sformatf("freeze%0d", k), 9'd30, windowF(30), 1'b0, 1'b1);
        end
        enable = 1'b1;
        start  = 1'b0;
        runSpan("edge", 31, 499, 500);

        // Continuous mode keeps running after the wrap. A pending write just
        // before reset must be discarded by it.
        runSpan("cont", 0, 58, 500);
        writeWindow(0, 0, 5);
        runSpan("cont", 59, 59, 500);
        clearWrites();
        runSpan("cont", 60, 60, 500);
        reset = 1'b1;
        applyStimulus();
        checkOutput("midreset", 9'd0, 4'hF, 1'b0, 1'b0);
        reset  = 1'b0;
        enable = 1'b0;
        mode   = 1'b1;
        setDefaults();
        applyStimulus();
        checkOutput("post_reset_idle", 9'd0, 4'hF, 1'b0, 1'b0);

        // One-shot: start ignored while disabled, no run without start.
        start = 1'b1;
        applyStimulus();
        checkOutput("os_start_dis", 9'd0, 4'hF, 1'b0, 1'b0);
        enable = 1'b1;
        start  = 1'b0;
        applyStimulus();
        checkOutput("os_nostart", 9'd0, 4'hF, 1'b0, 1'b0);
        start = 1'b1;
        applyStimulus();
        checkOutput("os_go", 9'd0, 4'hF, 1'b0, 1'b1);
        start = 1'b0;
        runSpan("os", 1, 99, 500);
        start = 1'b1;
        runSpan("os_restart", 100, 100, 500);
        start = 1'b0;
        mode  = 1'b0;
        runSpan("os_mode0", 101, 110, 500);
        mode  = 1'b1;
        runSpan("os", 111, 499, 500);
        applyStimulus();
        checkOutput("os_done", 9'd0, 4'hF, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("os_idle", 9'd0, 4'hF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
